// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy flags, overflow/underflow pulses and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is a registered read.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 1
) (
  input  logic              clk,
  input  logic              initb,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write_en,
  input  logic              read_en,
  input  logic              clr_err,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  output logic              ovf_sticky,
  output logic              unf_sticky
);

  localparam int              DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_V = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AF_V    = AF_LEVEL[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_V    = AE_LEVEL[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W:0] rd_ptr_reg, rd_ptr_next;
  logic            overflow_reg, overflow_next;
  logic            underflow_reg, underflow_next;
  logic            ovf_sticky_reg, ovf_sticky_next;
  logic            unf_sticky_reg, unf_sticky_next;
  logic [ADDR_W:0] count_w;
  logic            rd_acc, wr_acc;

  // Flags come from registered pointers only, so no enable-to-flag path exists.
  assign count_w      = wr_ptr_reg - rd_ptr_reg;
  assign count        = count_w;
  assign empty        = (count_w == '0);
  assign full         = (count_w == DEPTH_V);
  assign almost_full  = (count_w >= AF_V);
  assign almost_empty = (count_w <= AE_V);

  // A full FIFO still takes a write when the same cycle pops a word.
  assign rd_acc = read_en & ~empty;
  assign wr_acc = write_en & (~full | rd_acc);

  always_comb begin
    wr_ptr_next     = wr_ptr_reg + {{ADDR_W{1'b0}}, wr_acc};
    rd_ptr_next     = rd_ptr_reg + {{ADDR_W{1'b0}}, rd_acc};
    overflow_next   = write_en & ~wr_acc;
    underflow_next  = read_en & ~rd_acc;
    ovf_sticky_next = (ovf_sticky_reg & ~clr_err) | overflow_next;
    unf_sticky_next = (unf_sticky_reg & ~clr_err) | underflow_next;
  end

  always_ff @(posedge clk or negedge initb) begin
    if (!initb) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      overflow_reg   <= 1'b0;
      underflow_reg  <= 1'b0;
      ovf_sticky_reg <= 1'b0;
      unf_sticky_reg <= 1'b0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      overflow_reg   <= overflow_next;
      underflow_reg  <= underflow_next;
      ovf_sticky_reg <= ovf_sticky_next;
      unf_sticky_reg <= unf_sticky_next;
    end
  end

  assign overflow   = overflow_reg;
  assign underflow  = underflow_reg;
  assign ovf_sticky = ovf_sticky_reg;
  assign unf_sticky = unf_sticky_reg;

  // Storage is deliberately left unreset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_reg[ADDR_W-1:0]] <= data_in;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign data_out = mem[rd_ptr_reg[ADDR_W-1:0]];
`else
  logic [DATA_W-1:0] data_out_reg;

  always_ff @(posedge clk or negedge initb) begin
    if (!initb) begin
      data_out_reg <= '0;
    end else if (rd_acc) begin
      data_out_reg <= mem[rd_ptr_reg[ADDR_W-1:0]];
    end
  end

  assign data_out = data_out_reg;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: directed vector table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int DEPTH = 8;

  logic       clk;
  logic       initb;
  logic [7:0] data_in;
  logic       write_en, read_en, clr_err;
  logic [7:0] data_out;
  logic       full, empty, almost_full, almost_empty;
  logic [3:0] count;
  logic       overflow, underflow, ovf_sticky, unf_sticky;

  sync_fifo_param #(.DATA_W(8), .ADDR_W(3), .AF_LEVEL(6), .AE_LEVEL(1)) dut (
    .clk(clk), .initb(initb), .data_in(data_in), .write_en(write_en),
    .read_en(read_en), .clr_err(clr_err), .data_out(data_out), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow),
    .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_txn = 0;

  // Reference model: contents as a queue plus the observable registers.
  logic [7:0] q[$];
  logic [7:0] m_dout = 8'h00;
  logic       m_ovf = 0, m_unf = 0, m_ost = 0, m_ust = 0;

  typedef struct {
    logic       we, re, clr;
    logic [7:0] din;
    logic [3:0] cnt;
    logic [7:0] dout;
    logic       ovf, unf, ost, ust;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(input logic we, re, clr, input logic [7:0] din,
                              input logic [3:0] cnt, input logic [7:0] dout,
                              input logic ovf, unf, ost, ust);
    vec_t v;
    v.we = we; v.re = re; v.clr = clr; v.din = din; v.cnt = cnt; v.dout = dout;
    v.ovf = ovf; v.unf = unf; v.ost = ost; v.ust = ust;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = 8'h00;
    m_ovf = 0; m_unf = 0; m_ost = 0; m_ust = 0;
  endtask

  task automatic check_model();
    int sz;
    sz = q.size();
    chk("count", 32'(count), 32'(sz));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("full", 32'(full), 32'(sz == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(sz >= 6));
    chk("almost_empty", 32'(almost_empty), 32'(sz <= 1));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    chk("ovf_sticky", 32'(ovf_sticky), 32'(m_ost));
    chk("unf_sticky", 32'(unf_sticky), 32'(m_ust));
`ifdef SYNC_FIFO_FWFT_EN
    if (sz > 0) chk("data_out_head", 32'(data_out), 32'(q[0]));
`else
    chk("data_out", 32'(data_out), 32'(m_dout));
`endif
  endtask

  // One clock of stimulus: drive on the falling edge, update the model at the
  // rising edge, compare 1 time unit later.
  task automatic step(input logic we, input logic re, input logic clr, input logic [7:0] din);
    logic rd_ok, wr_ok;
    @(negedge clk);
    write_en = we; read_en = re; clr_err = clr; data_in = din;
    @(posedge clk);
    rd_ok = re && (q.size() > 0);
    wr_ok = we && ((q.size() < DEPTH) || rd_ok);
    if (rd_ok) m_dout = q.pop_front();
    if (wr_ok) q.push_back(din);
    m_ovf = we && !wr_ok;
    m_unf = re && !rd_ok;
    m_ost = (m_ost && !clr) || m_ovf;
    m_ust = (m_ust && !clr) || m_unf;
    #1;
    n_txn++;
    $display("txn %0d we=%0b re=%0b clr=%0b din=%02h -> count=%0d dout=%02h ovf=%0b unf=%0b",
             n_txn, we, re, clr, din, count, data_out, overflow, underflow);
    check_model();
  endtask

  initial begin
    // Directed sequence with hand-derived expected outputs (registered mode data).
    for (int i = 0; i < 8; i++)
      vecs[i] = mk(1, 0, 0, 8'(8'h11 + i), 4'(i + 1), 8'h00, 0, 0, 0, 0);
    vecs[8] = mk(1, 0, 0, 8'h99, 4'd8, 8'h00, 1, 0, 1, 0);
    vecs[9] = mk(1, 1, 0, 8'hA0, 4'd8, 8'h11, 0, 0, 1, 0);
    for (int i = 0; i < 7; i++)
      vecs[10 + i] = mk(0, 1, 0, 8'h00, 4'(7 - i), 8'(8'h12 + i), 0, 0, 1, 0);
    vecs[17] = mk(0, 1, 0, 8'h00, 4'd0, 8'hA0, 0, 0, 1, 0);
    vecs[18] = mk(1, 1, 0, 8'h55, 4'd1, 8'hA0, 0, 1, 1, 1);
    vecs[19] = mk(0, 1, 0, 8'h00, 4'd0, 8'h55, 0, 0, 1, 1);
    vecs[20] = mk(0, 0, 1, 8'h00, 4'd0, 8'h55, 0, 0, 0, 0);
    vecs[21] = mk(0, 1, 0, 8'h00, 4'd0, 8'h55, 0, 1, 0, 1);
    vecs[22] = mk(0, 1, 1, 8'h00, 4'd0, 8'h55, 0, 1, 0, 1);
    vecs[23] = mk(0, 0, 1, 8'h00, 4'd0, 8'h55, 0, 0, 0, 0);

    initb = 1'b0; write_en = 0; read_en = 0; clr_err = 0; data_in = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_almost_empty", 32'(almost_empty), 1);
    chk("rst_almost_full", 32'(almost_full), 0);
    chk("rst_flags", 32'({overflow, underflow, ovf_sticky, unf_sticky}), 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rst_data_out", 32'(data_out), 0);
`endif
    @(negedge clk);
    initb = 1'b1;

    for (int i = 0; i < 24; i++) begin
      step(vecs[i].we, vecs[i].re, vecs[i].clr, vecs[i].din);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].cnt == 4'd8));
      chk($sformatf("vec%0d_af", i), 32'(almost_full), 32'(vecs[i].cnt >= 4'd6));
      chk($sformatf("vec%0d_ae", i), 32'(almost_empty), 32'(vecs[i].cnt <= 4'd1));
      chk($sformatf("vec%0d_errs", i), 32'({overflow, underflow, ovf_sticky, unf_sticky}),
          32'({vecs[i].ovf, vecs[i].unf, vecs[i].ost, vecs[i].ust}));
`ifndef SYNC_FIFO_FWFT_EN
      chk($sformatf("vec%0d_dout", i), 32'(data_out), 32'(vecs[i].dout));
`endif
    end

    // Randomized traffic: write-heavy then read-heavy to visit full and empty.
    for (int i = 0; i < 400; i++) begin
      int wp;
      wp = (i < 200) ? 70 : 30;
      step(logic'($urandom_range(0, 99) < wp), logic'($urandom_range(0, 99) >= wp),
           logic'($urandom_range(0, 15) == 0), 8'($urandom));
    end

    // Drain, clear errors, then stream 20 words through with a read every cycle.
    repeat (DEPTH + 1) step(0, 1, 0, 8'h00);
    step(0, 0, 1, 8'h00);
    step(1, 0, 0, 8'h00);
    for (int i = 1; i < 20; i++) begin
      step(1, 1, 0, 8'(i));
      chk("wrap_count_le2", 32'(count <= 4'd2), 1);
      chk("wrap_no_errs", 32'({overflow, underflow, ovf_sticky, unf_sticky}), 0);
`ifndef SYNC_FIFO_FWFT_EN
      chk("wrap_order", 32'(data_out), 32'(i - 1));
`endif
    end
    step(0, 1, 0, 8'h00);

`ifdef SYNC_FIFO_FWFT_EN
    step(1, 0, 0, 8'h3C);
    chk("fwft_empty_fall", 32'(empty), 0);
    chk("fwft_show", 32'(data_out), 32'h3C);
    step(0, 1, 0, 8'h00);
    chk("fwft_pop_empty", 32'(empty), 1);
`endif

    // Reset in the middle of a burst with a sticky error pending.
    step(0, 1, 0, 8'h00);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'hC0 + i));
    chk("burst_count5", 32'(count), 5);
    @(negedge clk);
    initb = 1'b0; write_en = 1; read_en = 1;
    #1;
    model_reset();
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_full", 32'(full), 0);
    chk("mid_rst_ae_af", 32'({almost_empty, almost_full}), 32'b10);
    chk("mid_rst_flags", 32'({overflow, underflow, ovf_sticky, unf_sticky}), 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("mid_rst_data_out", 32'(data_out), 0);
`endif
    @(posedge clk);
    #1;
    chk("mid_rst_hold_count", 32'(count), 0);
    @(negedge clk);
    initb = 1'b1; write_en = 0; read_en = 0;
    step(0, 0, 0, 8'h00);
    step(1, 0, 0, 8'h5A);
    step(0, 1, 0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
